// File: rtl/button_input_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_input_pkg : debounce FSM state encoding and default timing constants
// Rev 1.0
// ---------------------------------------------------------------------------
package button_input_pkg;

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } state_t;

  // 10 ms debounce and 0.5 s auto-repeat at the 12 MHz board clock
  localparam int c_debounce_cycles_def = 120000;
  localparam int c_repeat_cycles_def   = 6000000;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_channel : synchroniser, debounce FSM, press pulse and toggle level
// Optional hold auto-repeat enabled by HOLD_REPEAT_EN.        Rev 1.0
// ---------------------------------------------------------------------------
module debounce_channel
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_debounce_cycles_def,
  parameter int BTN_ACTIVE_LOW  = 1
`ifdef HOLD_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = c_repeat_cycles_def
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic               c_rel_lvl = (BTN_ACTIVE_LOW != 0);

  logic               r_sync1;
  logic               r_sync2;
  logic               w_p;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_commit;
  logic               w_toggle;
  logic               r_press;
  logic               r_level;

  // Sync flops reset to the released pad level so reset never looks like a press
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= c_rel_lvl;
      r_sync2 <= c_rel_lvl;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = r_sync2 ^ c_rel_lvl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= REL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      REL: begin
        if (w_p) begin
          w_state_nxt = REL_CHK;
          w_cnt_nxt   = '0;
        end
      end
      REL_CHK: begin
        if (!w_p) begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = PRS;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      PRS: begin
        if (!w_p) begin
          w_state_nxt = PRS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      PRS_CHK: begin
        if (w_p) begin
          w_state_nxt = PRS;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_max) begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = REL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HOLD_REPEAT_EN
  localparam int                 c_rpt_w   = $clog2(REPEAT_CYCLES);
  localparam logic [c_rpt_w-1:0] c_rpt_max = c_rpt_w'(REPEAT_CYCLES - 1);

  logic [c_rpt_w-1:0] r_rcnt;
  logic               w_hold;
  logic               w_rpt_fire;

  // Repeat only while the press stays committed; leaving PRS restarts the hold time
  assign w_hold     = (r_state == PRS) && (w_state_nxt == PRS);
  assign w_rpt_fire = w_hold && (r_rcnt == c_rpt_max);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rcnt <= '0;
    end else if (!w_hold || w_rpt_fire) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end

  assign w_toggle = w_commit | w_rpt_fire;
`else
  assign w_toggle = w_commit;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_press <= w_toggle;
      r_level <= r_level ^ w_toggle;
    end
  end

  assign o_press = r_press;
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/button_input_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_input_stage : two debounced, toggling pushbutton channels (A and B)
// Optional hold auto-repeat enabled by HOLD_REPEAT_EN.        Rev 1.0
// ---------------------------------------------------------------------------
module button_input_stage
  import button_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_debounce_cycles_def,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int REPEAT_CYCLES   = c_repeat_cycles_def
) (
  input  logic CLK_IN,
  input  logic RST_N_IN,
  input  logic BTN_A_IN,
  input  logic BTN_B_IN,
  output logic A_OUT,
  output logic B_OUT,
  output logic A_PRESS_OUT,
  output logic B_PRESS_OUT
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
`ifdef HOLD_REPEAT_EN
    ,
    .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
  ) u_ch_a (
    .i_clk   (CLK_IN),
    .i_rst_n (RST_N_IN),
    .i_btn   (BTN_A_IN),
    .o_level (A_OUT),
    .o_press (A_PRESS_OUT)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
`ifdef HOLD_REPEAT_EN
    ,
    .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
  ) u_ch_b (
    .i_clk   (CLK_IN),
    .i_rst_n (RST_N_IN),
    .i_btn   (BTN_B_IN),
    .o_level (B_OUT),
    .o_press (B_PRESS_OUT)
  );

endmodule
`default_nettype wire

// File: tb/tb_button_input_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_button_input_stage : table-driven bench, DEBOUNCE=4, REPEAT=10, active-low
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_button_input_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_a;
  logic btn_b;
  logic a_out;
  logic b_out;
  logic a_press;
  logic b_press;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  button_input_stage #(
    .DEBOUNCE_CYCLES (4),
    .BTN_ACTIVE_LOW  (1),
    .REPEAT_CYCLES   (10)
  ) dut (
    .CLK_IN      (clk),
    .RST_N_IN    (rst_n),
    .BTN_A_IN    (btn_a),
    .BTN_B_IN    (btn_b),
    .A_OUT       (a_out),
    .B_OUT       (b_out),
    .A_PRESS_OUT (a_press),
    .B_PRESS_OUT (b_press)
  );

  // One row = inputs held for n cycles, expected outputs checked every cycle
  typedef struct {
    logic a;
    logic b;
    logic rst_n;
    int   n;
    logic ea;
    logic eb;
    logic epa;
    logic epb;
  } vec_t;

  vec_t vecs[$];

  // A_OUT level once the 20-cycle hold of the first press is over
`ifdef HOLD_REPEAT_EN
  localparam logic c_a2 = 1'b0;
`else
  localparam logic c_a2 = 1'b1;
`endif

  function automatic void add(input logic a, input logic b, input logic r, input int n,
                              input logic ea, input logic eb, input logic epa, input logic epb);
    vec_t v;
    v.a = a; v.b = b; v.rst_n = r; v.n = n;
    v.ea = ea; v.eb = eb; v.epa = epa; v.epb = epb;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int row, input int cyc,
                     input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d cycle %0d: got %b expected %b", name, row, cyc, act, exp);
    end
  endtask

  initial begin
    // reset with A pressed: nothing may come out
    add(0, 1, 0, 3,  0, 0, 0, 0);
    add(1, 1, 1, 10, 0, 0, 0, 0);
    // clean press of A held 20 cycles, pulse on the 7th
    add(0, 1, 1, 6,  0, 0, 0, 0);
    add(0, 1, 1, 1,  1, 0, 1, 0);
`ifdef HOLD_REPEAT_EN
    add(0, 1, 1, 9,  1, 0, 0, 0);
    add(0, 1, 1, 1,  0, 0, 1, 0);
    add(0, 1, 1, 3,  0, 0, 0, 0);
`else
    add(0, 1, 1, 13, 1, 0, 0, 0);
`endif
    add(1, 1, 1, 10, c_a2, 0, 0, 0);
    // bounce: low 3, high 1, low 3, high
    add(0, 1, 1, 3,  c_a2, 0, 0, 0);
    add(1, 1, 1, 1,  c_a2, 0, 0, 0);
    add(0, 1, 1, 3,  c_a2, 0, 0, 0);
    add(1, 1, 1, 10, c_a2, 0, 0, 0);
    // two presses of A, 10 cycles each with 10-cycle release
    add(0, 1, 1, 6,  c_a2, 0, 0, 0);
    add(0, 1, 1, 1,  ~c_a2, 0, 1, 0);
    add(0, 1, 1, 3,  ~c_a2, 0, 0, 0);
    add(1, 1, 1, 10, ~c_a2, 0, 0, 0);
    add(0, 1, 1, 6,  ~c_a2, 0, 0, 0);
    add(0, 1, 1, 1,  c_a2, 0, 1, 0);
    add(0, 1, 1, 3,  c_a2, 0, 0, 0);
    add(1, 1, 1, 10, c_a2, 0, 0, 0);
    // A and B pressed in the same cycle
    add(0, 0, 1, 6,  c_a2, 0, 0, 0);
    add(0, 0, 1, 1,  ~c_a2, 1, 1, 1);
    add(0, 0, 1, 3,  ~c_a2, 1, 0, 0);
    add(1, 1, 1, 10, ~c_a2, 1, 0, 0);
    // B alone: A channel untouched
    add(1, 0, 1, 6,  ~c_a2, 1, 0, 0);
    add(1, 0, 1, 1,  ~c_a2, 0, 0, 1);
    add(1, 0, 1, 3,  ~c_a2, 0, 0, 0);
    add(1, 1, 1, 10, ~c_a2, 0, 0, 0);
    // reset 2 cycles into a press, then full re-debounce while held 40 cycles
    add(0, 1, 1, 2,  ~c_a2, 0, 0, 0);
    add(0, 1, 0, 2,  0, 0, 0, 0);
    add(0, 1, 1, 6,  0, 0, 0, 0);
    add(0, 1, 1, 1,  1, 0, 1, 0);
`ifdef HOLD_REPEAT_EN
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 1, 9, ((k % 2) == 0) ? 1'b1 : 1'b0, 0, 0, 0);
      add(0, 1, 1, 1, ((k % 2) == 0) ? 1'b0 : 1'b1, 0, 1, 0);
    end
`else
    add(0, 1, 1, 40, 1, 0, 0, 0);
`endif
    add(1, 1, 1, 10, 1, 0, 0, 0);

    // inputs change just after a falling edge, outputs are checked at the next one
    for (int r = 0; r < vecs.size(); r++) begin
      btn_a = vecs[r].a;
      btn_b = vecs[r].b;
      rst_n = vecs[r].rst_n;
      for (int c = 0; c < vecs[r].n; c++) begin
        @(negedge clk);
        chk("A_OUT",       r, c, a_out,   vecs[r].ea);
        chk("B_OUT",       r, c, b_out,   vecs[r].eb);
        chk("A_PRESS_OUT", r, c, a_press, vecs[r].epa);
        chk("B_PRESS_OUT", r, c, b_press, vecs[r].epb);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
